// File: rtl/power_burst_detector.sv
// power_burst_detector
//   Turns a signed 12-bit moving-average power estimate into burst start/end
//   events. Dual-threshold hysteresis with dwell qualification on entry and
//   exit, followed by a fixed hold-off. Peak power and duration (valid-sample
//   count) of each completed burst are reported at its end.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a valid sample at or above ip_thr_on
//   QUALIFY | counting consecutive high samples up to DWELL_ON
//   ACTIVE  | burst in progress; counting consecutive low samples
//   HOLDOFF | ignoring input for HOLDOFF clock cycles after a burst
//
// Ports
//   ip_clock     clock; all registers update on the falling edge
//   ip_reset     asynchronous active-high reset
//   ip_power     signed power estimate
//   ip_valid     ip_power holds a new sample this cycle
//   ip_thr_on    signed start threshold (high: power >= thr_on)
//   ip_thr_off   signed end threshold   (low:  power <  thr_off)
//   ip_enable    detector enable
//   op_detect    high while in ACTIVE
//   op_start     one-cycle pulse on entry to ACTIVE
//   op_end       one-cycle pulse on exit from ACTIVE
//   op_peak      signed maximum power of the last completed burst
//   op_duration  valid-sample count of the last completed burst (saturating)
//   op_state     current FSM state encoding
module power_burst_detector #(
   parameter int DWELL_ON  = 8,
   parameter int DWELL_OFF = 16,
   parameter int HOLDOFF   = 32
) (
   input  logic               ip_clock,
   input  logic               ip_reset,
   input  logic signed [11:0] ip_power,
   input  logic               ip_valid,
   input  logic signed [11:0] ip_thr_on,
   input  logic signed [11:0] ip_thr_off,
   input  logic               ip_enable,
   output logic               op_detect,
   output logic               op_start,
   output logic               op_end,
   output logic signed [11:0] op_peak,
   output logic [15:0]        op_duration,
   output logic [1:0]         op_state
);

   localparam logic [7:0] DWELL_ON_C  = 8'(DWELL_ON);
   localparam logic [7:0] DWELL_OFF_C = 8'(DWELL_OFF);
   localparam logic [7:0] HOLD_LAST_C = 8'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_QUALIFY = 2'd1,
      S_ACTIVE  = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         on_cnt;
   logic [7:0]         off_cnt;
   logic [7:0]         hold_cnt;
   logic signed [11:0] run_peak;
   logic [15:0]        run_dur;

   logic               is_high;
   logic               is_low;
   logic signed [11:0] peak_next;
   logic [15:0]        dur_next;
   logic [7:0]         on_next;
   logic [7:0]         off_next;

   assign is_high   = (ip_power >= ip_thr_on);
   assign is_low    = (ip_power < ip_thr_off);
   assign peak_next = (ip_power > run_peak) ? ip_power : run_peak;
   assign dur_next  = (run_dur == 16'hFFFF) ? run_dur : run_dur + 16'd1;
   assign on_next   = on_cnt + 8'd1;
   assign off_next  = off_cnt + 8'd1;
   assign op_state  = state;

   always_ff @(negedge ip_clock or posedge ip_reset) begin
      if (ip_reset) begin
         state       <= S_IDLE;
         on_cnt      <= 8'd0;
         off_cnt     <= 8'd0;
         hold_cnt    <= 8'd0;
         run_peak    <= 12'sd0;
         run_dur     <= 16'd0;
         op_detect   <= 1'b0;
         op_start    <= 1'b0;
         op_end      <= 1'b0;
         op_peak     <= 12'sd0;
         op_duration <= 16'd0;
      end else begin
         op_start <= 1'b0;
         op_end   <= 1'b0;
         case (state)
            S_IDLE: begin
               on_cnt   <= 8'd0;
               off_cnt  <= 8'd0;
               hold_cnt <= 8'd0;
               if (ip_enable && ip_valid && is_high) begin
                  on_cnt   <= 8'd1;
                  run_peak <= ip_power;
                  run_dur  <= 16'd1;
                  // a single qualifying sample is enough when DWELL_ON is 1
                  if (DWELL_ON_C == 8'd1) begin
                     state     <= S_ACTIVE;
                     op_start  <= 1'b1;
                     op_detect <= 1'b1;
                  end else begin
                     state <= S_QUALIFY;
                  end
               end
            end
            S_QUALIFY: begin
               if (!ip_enable) begin
                  state  <= S_IDLE;
                  on_cnt <= 8'd0;
               end else if (ip_valid) begin
                  if (is_high) begin
                     on_cnt   <= on_next;
                     run_peak <= peak_next;
                     run_dur  <= dur_next;
                     if (on_next == DWELL_ON_C) begin
                        state     <= S_ACTIVE;
                        op_start  <= 1'b1;
                        op_detect <= 1'b1;
                        off_cnt   <= 8'd0;
                     end
                  end else begin
                     state  <= S_IDLE;
                     on_cnt <= 8'd0;
                  end
               end
            end
            S_ACTIVE: begin
               if (!ip_enable) begin
                  // forced exit reports what was gathered so far; no hold-off
                  state       <= S_IDLE;
                  op_end      <= 1'b1;
                  op_detect   <= 1'b0;
                  op_peak     <= run_peak;
                  op_duration <= run_dur;
                  on_cnt      <= 8'd0;
                  off_cnt     <= 8'd0;
               end else if (ip_valid) begin
                  run_peak <= peak_next;
                  run_dur  <= dur_next;
                  if (is_low) begin
                     off_cnt <= off_next;
                     if (off_next == DWELL_OFF_C) begin
                        state       <= S_HOLDOFF;
                        op_end      <= 1'b1;
                        op_detect   <= 1'b0;
                        op_peak     <= peak_next;
                        op_duration <= dur_next;
                        hold_cnt    <= 8'd0;
                     end
                  end else begin
                     off_cnt <= 8'd0;
                  end
               end
            end
            S_HOLDOFF: begin
               if (!ip_enable || hold_cnt == HOLD_LAST_C) begin
                  state    <= S_IDLE;
                  hold_cnt <= 8'd0;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_power_burst_detector.sv
module tb_power_burst_detector;

   localparam int DON  = 8;
   localparam int DOFF = 16;
   localparam int HOLD = 32;

   logic               ip_clock;
   logic               ip_reset;
   logic signed [11:0] ip_power;
   logic               ip_valid;
   logic signed [11:0] ip_thr_on;
   logic signed [11:0] ip_thr_off;
   logic               ip_enable;
   logic               op_detect;
   logic               op_start;
   logic               op_end;
   logic signed [11:0] op_peak;
   logic [15:0]        op_duration;
   logic [1:0]         op_state;

   int n_checks = 0;
   int n_pass   = 0;

   power_burst_detector #(.DWELL_ON(DON), .DWELL_OFF(DOFF), .HOLDOFF(HOLD)) dut (
      .ip_clock(ip_clock), .ip_reset(ip_reset), .ip_power(ip_power),
      .ip_valid(ip_valid), .ip_thr_on(ip_thr_on), .ip_thr_off(ip_thr_off),
      .ip_enable(ip_enable), .op_detect(op_detect), .op_start(op_start),
      .op_end(op_end), .op_peak(op_peak), .op_duration(op_duration),
      .op_state(op_state)
   );

   initial begin
      ip_clock = 1'b1;
      forever #5 ip_clock = ~ip_clock;
   end

   // Behavioural model: burst phase plus run lengths of consecutive
   // high/low valid samples and a remaining hold-off budget.
   int m_phase;      // 0 idle, 1 qualifying, 2 in burst, 3 hold-off
   int m_hi_run;
   int m_lo_run;
   int m_hold_left;
   int m_peak;
   int m_dur;
   int m_out_peak;
   int m_out_dur;
   bit m_start;
   bit m_end;
   int m_p;
   bit m_hi;
   bit m_lo;

   always @(negedge ip_clock or posedge ip_reset) begin
      if (ip_reset) begin
         m_phase = 0; m_hi_run = 0; m_lo_run = 0; m_hold_left = 0;
         m_peak = 0; m_dur = 0; m_out_peak = 0; m_out_dur = 0;
         m_start = 0; m_end = 0;
      end else begin
         m_p  = int'(ip_power);
         m_hi = (m_p >= int'(ip_thr_on));
         m_lo = (m_p < int'(ip_thr_off));
         m_start = 0;
         m_end   = 0;
         if (!ip_enable) begin
            if (m_phase == 2) begin
               m_end = 1; m_out_peak = m_peak; m_out_dur = m_dur;
            end
            m_phase = 0; m_hi_run = 0;
         end else if (m_phase == 3) begin
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) m_phase = 0;
         end else if (ip_valid) begin
            if (m_phase == 2) begin
               m_dur  = (m_dur >= 65535) ? 65535 : m_dur + 1;
               m_peak = (m_p > m_peak) ? m_p : m_peak;
               m_lo_run = m_lo ? m_lo_run + 1 : 0;
               if (m_lo_run == DOFF) begin
                  m_end = 1; m_out_peak = m_peak; m_out_dur = m_dur;
                  m_phase = 3; m_hold_left = HOLD;
               end
            end else if (m_hi) begin
               if (m_hi_run == 0) begin m_peak = m_p; m_dur = 0; end
               m_hi_run = m_hi_run + 1;
               m_dur    = m_dur + 1;
               m_peak   = (m_p > m_peak) ? m_p : m_peak;
               if (m_hi_run == DON) begin
                  m_phase = 2; m_start = 1; m_hi_run = 0; m_lo_run = 0;
               end else begin
                  m_phase = 1;
               end
            end else begin
               m_phase = 0; m_hi_run = 0;
            end
         end
      end
   end

   always @(posedge ip_clock) begin
      n_checks++;
      if (op_state == 2'(m_phase) && op_detect == (m_phase == 2) &&
          op_start == m_start && op_end == m_end &&
          int'(op_peak) == m_out_peak && int'(op_duration) == m_out_dur)
         n_pass++;
      else
         $display("FAIL model_cmp t=%0t: got st=%0d det=%0d s=%0d e=%0d pk=%0d dur=%0d expected st=%0d det=%0d s=%0d e=%0d pk=%0d dur=%0d",
                  $time, op_state, op_detect, op_start, op_end, op_peak, op_duration,
                  m_phase, (m_phase == 2), m_start, m_end, m_out_peak, m_out_dur);
   end

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Present a sample, then return at the next rising edge, by which time the
   // falling edge has evaluated it.
   task automatic step(input int p, input bit v);
      ip_power = 12'(p);
      ip_valid = v;
      @(posedge ip_clock);
   endtask

   task automatic run(input int p, input int n);
      for (int i = 0; i < n; i++) step(p, 1'b1);
   endtask

   initial begin
      ip_reset   = 1'b1;
      ip_power   = '0;
      ip_valid   = 1'b0;
      ip_thr_on  = 12'sd400;
      ip_thr_off = 12'sd300;
      ip_enable  = 1'b1;
      repeat (3) @(posedge ip_clock);
      chk("reset_state", int'(op_state), 0);
      chk("reset_peak", int'(op_peak), 0);
      ip_reset = 1'b0;
      run(0, 3);

      // short burst
      step(500, 1'b1);
      chk("short_qualify", int'(op_state), 1);
      run(500, 6);
      chk("short_no_start", int'(op_start), 0);
      step(100, 1'b1);
      chk("short_back_idle", int'(op_state), 0);
      run(100, 2);
      chk("short_peak", int'(op_peak), 0);
      chk("short_dur", int'(op_duration), 0);

      // full burst
      run(500, 7);
      chk("full_pre_start", int'(op_start), 0);
      step(500, 1'b1);
      chk("full_start", int'(op_start), 1);
      chk("full_detect", int'(op_detect), 1);
      run(350, 10);
      chk("full_start_pulse", int'(op_start), 0);
      step(900, 1'b1);
      run(350, 9);
      run(100, 15);
      chk("full_no_early_end", int'(op_end), 0);
      step(100, 1'b1);
      chk("full_end", int'(op_end), 1);
      chk("full_peak", int'(op_peak), 900);
      chk("full_dur", int'(op_duration), 44);
      chk("full_holdoff", int'(op_state), 3);
      run(100, 31);
      chk("full_holdoff_last", int'(op_state), 3);
      step(500, 1'b1);
      chk("holdoff_last_ignored", int'(op_state), 0);
      run(100, 3);

      // hysteresis
      run(500, 8);
      chk("hyst_start", int'(op_start), 1);
      run(100, 15);
      step(350, 1'b1);
      run(100, 15);
      chk("hyst_no_end", int'(op_state), 2);
      step(100, 1'b1);
      chk("hyst_end", int'(op_end), 1);
      chk("hyst_dur", int'(op_duration), 40);
      chk("hyst_peak", int'(op_peak), 500);
      run(100, 35);

      // valid gaps
      for (int i = 1; i <= 14; i++) step(500, i[0]);
      chk("gap_qualify", int'(op_state), 1);
      step(500, 1'b1);
      chk("gap_start", int'(op_start), 1);
      run(100, 16);
      chk("gap_end", int'(op_end), 1);
      run(500, 32);
      chk("gap_idle_again", int'(op_state), 0);
      run(500, 7);
      chk("gap_requal", int'(op_state), 1);
      step(500, 1'b1);
      chk("gap_restart", int'(op_start), 1);
      run(100, 16 + 35);

      // disable mid-burst
      run(500, 11);
      chk("dis_active", int'(op_state), 2);
      ip_enable = 1'b0;
      step(500, 1'b1);
      chk("dis_end", int'(op_end), 1);
      chk("dis_state", int'(op_state), 0);
      chk("dis_dur", int'(op_duration), 11);
      run(500, 5);
      chk("dis_stay_idle", int'(op_state), 0);
      ip_enable = 1'b1;
      run(100, 3);

      // reset mid-burst
      run(500, 10);
      chk("rst_active", int'(op_state), 2);
      #2 ip_reset = 1'b1;
      #1;
      chk("rst_async_state", int'(op_state), 0);
      chk("rst_async_detect", int'(op_detect), 0);
      chk("rst_async_peak", int'(op_peak), 0);
      chk("rst_async_dur", int'(op_duration), 0);
      repeat (2) @(posedge ip_clock);
      ip_reset = 1'b0;
      run(500, 7);
      chk("rst_requal", int'(op_start), 0);
      step(500, 1'b1);
      chk("rst_restart", int'(op_start), 1);
      run(100, 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
